// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester and the PS/2 host transmitter.
// The requester drives tx_data/tx_valid. The transmitter reports ready, busy and the frame outcome.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, tx_done, tx_error
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, tx_done, tx_error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, sends start/8 data/odd parity/stop
// on the device's clock, and checks the device ACK. Pins are open-drain through *_oe.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_CYCLES  = 8
) (
    input  logic          clock,
    input  logic          reset,
    ps2_host_tx_if.slave  tx,
    input  logic          ps2_clk_in,
    input  logic          ps2_data_in,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe
);

    localparam int TMR_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int FLT_W   = $clog2(FILTER_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_START, S_SEND, S_ACK, S_WAIT_IDLE
    } state_t;

    state_t             state, state_next;
    logic [1:0]         meta, sync, filt;          // bit 0 = clock line, bit 1 = data line
    logic [FLT_W-1:0]   flt_cnt [2];
    logic               clk_filt_d;
    logic               fall, clk_f, data_f;
    logic [TMR_W-1:0]   tmr;
    logic [3:0]         bitcnt;
    logic [7:0]         shift;
    logic               parity;
    logic [2:0]         bit_idx;
    logic               accept, timeout, inhibit_end, bit_oe;

    // A change on a synced line only reaches the filtered value after FILTER_CYCLES
    // consecutive disagreeing cycles, so short glitches never produce a fall.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            meta       <= 2'b11;
            sync       <= 2'b11;
            filt       <= 2'b11;
            clk_filt_d <= 1'b1;
            for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
        end else begin
            meta       <= {ps2_data_in, ps2_clk_in};
            sync       <= meta;
            clk_filt_d <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync[i] == filt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == FLT_W'(FILTER_CYCLES - 1)) begin
                    filt[i]    <= sync[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign clk_f       = filt[0];
    assign data_f      = filt[1];
    assign fall        = clk_filt_d & ~clk_f;
    assign accept      = tx.tx_valid && (state == S_IDLE);
    assign timeout     = (tmr == TMR_W'(TIMEOUT_CYCLES));
    assign inhibit_end = (tmr == TMR_W'(INHIBIT_CYCLES - 1));
    assign bit_idx     = bitcnt[2:0] - 3'd1;

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:      if (accept) state_next = S_INHIBIT;
            S_INHIBIT:   if (inhibit_end) state_next = S_START;
            S_START:     state_next = S_SEND;
            S_SEND:      if (timeout) state_next = S_IDLE;
                         else if (fall && bitcnt == 4'd9) state_next = S_ACK;
            S_ACK:       if (timeout) state_next = S_IDLE;
                         else if (fall) state_next = data_f ? S_IDLE : S_WAIT_IDLE;
            S_WAIT_IDLE: if (timeout || (clk_f && data_f)) state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // Data follows bitcnt, which only moves on a fall, so the line is stable at device rising edges.
    always_comb begin
        bit_oe = 1'b0;
        if (bitcnt == 4'd0)      bit_oe = 1'b1;
        else if (bitcnt <= 4'd8) bit_oe = ~shift[bit_idx];
        else if (bitcnt == 4'd9) bit_oe = ~parity;
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no latch can be inferred.
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        tx.tx_ready = 1'b0;
        tx.tx_done  = 1'b0;
        tx.tx_error = 1'b0;
        unique case (state)
            S_IDLE:      tx.tx_ready = 1'b1;
            S_INHIBIT:   ps2_clk_oe  = 1'b1;
            S_START: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
            end
            S_SEND: begin
                ps2_data_oe = bit_oe;
                tx.tx_error = timeout;
            end
            S_ACK:       tx.tx_error = timeout || (fall && data_f);
            S_WAIT_IDLE: begin
                tx.tx_error = timeout;
                tx.tx_done  = !timeout && clk_f && data_f;
            end
            default: ;
        endcase
        tx.busy = ~tx.tx_ready;
    end

    // One timer serves both the inhibit length and the inter-fall timeout.
    always_ff @(posedge clock) begin
        if (reset) begin
            tmr    <= '0;
            bitcnt <= '0;
            shift  <= '0;
            parity <= 1'b0;
        end else begin
            if (accept) begin
                shift  <= tx.tx_data;
                parity <= ~^tx.tx_data;
                bitcnt <= '0;
            end else if (state == S_SEND && fall) begin
                bitcnt <= bitcnt + 4'd1;
            end

            if (state == S_IDLE || state_next != state)
                tmr <= '0;
            else if (fall && (state inside {S_SEND, S_ACK, S_WAIT_IDLE}))
                tmr <= '0;
            else
                tmr <= tmr + 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a behavioural PS/2 device drives the open-drain
// lines and each frame is compared with the bit sequence derived from the command byte.
module tb_ps2_host_tx;

    localparam int INHIBIT = 100;
    localparam int FILTER  = 4;
    localparam int TIMEOUT = 5000;
    localparam int HALF    = 200;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    logic ps2_clk_oe, ps2_data_oe;
    logic ps2_clk_in, ps2_data_in;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, ready_late = 0, ready_early = 0;
    logic pulse_prev = 1'b0;

    ps2_host_tx_if bus ();

    // Wired-AND of the two open-drain drivers with pull-ups.
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT),
        .FILTER_CYCLES (FILTER)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .tx         (bus),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.tx_done) done_cnt++;
        if (bus.tx_error) err_cnt++;
        if (bus.tx_done && bus.tx_error) both_cnt++;
        if (pulse_prev && !bus.tx_ready) ready_late++;
        if ((bus.tx_done || bus.tx_error) && bus.tx_ready) ready_early++;
        pulse_prev = bus.tx_done | bus.tx_error;
    end

    // Reference frame: element i is the data line value at the device's i-th rising edge.
    function automatic logic [10:0] expected_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        f[0]   = 1'b0;
        f[8:1] = b;
        f[9]   = (ones % 2 == 0);
        f[10]  = 1'b1;
        return f;
    endfunction

    task automatic send_req(input logic [7:0] b);
        @(negedge clock);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        @(negedge clock);
        bus.tx_valid = 1'b0;
    endtask

    // Device side of a frame. abort_after leaves the clock held low after that fall;
    // glitch_after adds a 2-cycle low pulse in the high phase after that rise.
    task automatic device_frame(input bit ack, input int glitch_after, input int abort_after,
                                output logic [10:0] bits, output bit started);
        bits    = '1;
        started = 1'b0;
        for (int n = 0; n < 2000 && !started; n++) begin
            @(negedge clock);
            started = !ps2_clk_oe && ps2_data_oe;
        end
        if (!started) return;
        bits[0] = ps2_data_in;
        for (int i = 1; i <= 10; i++) begin
            repeat (HALF) @(negedge clock);
            dev_clk_low = 1'b1;
            if (i == abort_after) begin
                repeat (20) @(negedge clock);
                return;
            end
            repeat (HALF) @(negedge clock);
            dev_clk_low = 1'b0;
            bits[i] = ps2_data_in;
            if (i == glitch_after) begin
                repeat (HALF / 2) @(negedge clock);
                dev_clk_low = 1'b1;
                repeat (2) @(negedge clock);
                dev_clk_low = 1'b0;
            end
        end
        repeat (HALF / 2) @(negedge clock);
        if (ack) dev_data_low = 1'b1;
        repeat (HALF / 2) @(negedge clock);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clock);
        dev_clk_low = 1'b0;
        repeat (HALF / 4) @(negedge clock);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_outcome(input int done0, input int err0, output int d_done, output int d_err);
        for (int n = 0; n < 400 && done_cnt == done0 && err_cnt == err0; n++) @(negedge clock);
        repeat (5) @(negedge clock);
        d_done = done_cnt - done0;
        d_err  = err_cnt - err0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({bus.tx_ready, bus.busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_ready_busy: got %b expected 10", {bus.tx_ready, bus.busy});
        end
        checks++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            errors++;
            $display("FAIL reset_oe: got %b expected 00", {ps2_clk_oe, ps2_data_oe});
        end
        checks++;
        if ({bus.tx_done, bus.tx_error} !== 2'b00) begin
            errors++;
            $display("FAIL reset_pulses: got %b expected 00", {bus.tx_done, bus.tx_error});
        end
    endtask

    task automatic test_inhibit_and_ack();
        logic [10:0] bits;
        bit started;
        int n = 0, d_done, d_err, done0 = done_cnt, err0 = err_cnt;
        send_req(8'hED);
        while (ps2_clk_oe && !ps2_data_oe && n < 1000) begin
            n++;
            @(negedge clock);
        end
        checks++;
        if (n != INHIBIT) begin
            errors++;
            $display("FAIL inhibit_len: got %0d expected %0d", n, INHIBIT);
        end
        checks++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b11) begin
            errors++;
            $display("FAIL start_oe: got %b expected 11", {ps2_clk_oe, ps2_data_oe});
        end
        @(negedge clock);
        checks++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b01) begin
            errors++;
            $display("FAIL send_entry_oe: got %b expected 01", {ps2_clk_oe, ps2_data_oe});
        end
        device_frame(1'b1, 0, 0, bits, started);
        checks++;
        if (!started) begin
            errors++;
            $display("FAIL ed_started: got 0 expected 1");
        end
        checks++;
        if (bits !== expected_frame(8'hED)) begin
            errors++;
            $display("FAIL ed_bits: got %b expected %b", bits, expected_frame(8'hED));
        end
        wait_outcome(done0, err0, d_done, d_err);
        checks++;
        if (d_done != 1 || d_err != 0) begin
            errors++;
            $display("FAIL ed_outcome: got done=%0d err=%0d expected done=1 err=0", d_done, d_err);
        end
        checks++;
        if (bus.tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL ed_ready: got %b expected 1", bus.tx_ready);
        end
    endtask

    task automatic run_frame(input string name, input logic [7:0] b, input bit ack);
        logic [10:0] bits;
        bit started;
        int d_done, d_err, done0 = done_cnt, err0 = err_cnt;
        send_req(b);
        device_frame(ack, 0, 0, bits, started);
        checks++;
        if (bits !== expected_frame(b)) begin
            errors++;
            $display("FAIL %s_bits: byte %h got %b expected %b", name, b, bits, expected_frame(b));
        end
        wait_outcome(done0, err0, d_done, d_err);
        checks++;
        if (d_done != int'(ack) || d_err != int'(!ack)) begin
            errors++;
            $display("FAIL %s_outcome: got done=%0d err=%0d expected done=%0d err=%0d",
                     name, d_done, d_err, int'(ack), int'(!ack));
        end
        checks++;
        if (bus.tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: got %b expected 1", name, bus.tx_ready);
        end
    endtask

    task automatic test_nack();
        run_frame("nack", 8'h00, 1'b0);
    endtask

    task automatic test_timeout();
        int k = 0, n = 0, d_done, d_err, done0 = done_cnt, err0 = err_cnt;
        send_req(8'($urandom));
        while (ps2_clk_oe && n < 300) begin
            n++;
            @(negedge clock);
        end
        while (!bus.tx_error && k < TIMEOUT + 1000) begin
            k++;
            @(negedge clock);
        end
        checks++;
        if (k != TIMEOUT) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d expected %0d", k, TIMEOUT);
        end
        @(negedge clock);
        checks++;
        if ({ps2_clk_oe, ps2_data_oe, bus.tx_ready} !== 3'b001) begin
            errors++;
            $display("FAIL timeout_release: got oe/ready %b expected 001",
                     {ps2_clk_oe, ps2_data_oe, bus.tx_ready});
        end
        wait_outcome(done0, err0, d_done, d_err);
        checks++;
        if (d_done != 0 || d_err != 1) begin
            errors++;
            $display("FAIL timeout_outcome: got done=%0d err=%0d expected done=0 err=1", d_done, d_err);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] bits;
        bit started;
        int done0 = done_cnt, err0 = err_cnt;
        send_req(8'($urandom));
        device_frame(1'b1, 0, 4, bits, started);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({ps2_clk_oe, ps2_data_oe, bus.tx_ready} !== 3'b001) begin
            errors++;
            $display("FAIL midreset_release: got oe/ready %b expected 001",
                     {ps2_clk_oe, ps2_data_oe, bus.tx_ready});
        end
        reset = 1'b0;
        dev_clk_low = 1'b0;
        repeat (50) @(negedge clock);
        checks++;
        if (done_cnt != done0 || err_cnt != err0) begin
            errors++;
            $display("FAIL midreset_pulses: got done=%0d err=%0d expected 0 0",
                     done_cnt - done0, err_cnt - err0);
        end
        run_frame("after_reset", 8'hFF, 1'b1);
    endtask

    task automatic test_glitch_and_busy();
        logic [10:0] bits;
        bit started, saw_oe = 1'b0;
        logic [7:0] b = 8'($urandom);
        int d_done, d_err, done0 = done_cnt, err0 = err_cnt;
        send_req(b);
        fork
            device_frame(1'b1, 4, 0, bits, started);
            begin
                repeat (300) @(negedge clock);
                bus.tx_data  = ~b;
                bus.tx_valid = 1'b1;
                @(negedge clock);
                bus.tx_valid = 1'b0;
                repeat (2000) @(negedge clock);
                bus.tx_data  = 8'hA5;
                bus.tx_valid = 1'b1;
                @(negedge clock);
                bus.tx_valid = 1'b0;
            end
        join
        checks++;
        if (bits !== expected_frame(b)) begin
            errors++;
            $display("FAIL glitch_bits: byte %h got %b expected %b", b, bits, expected_frame(b));
        end
        wait_outcome(done0, err0, d_done, d_err);
        checks++;
        if (d_done != 1 || d_err != 0) begin
            errors++;
            $display("FAIL glitch_outcome: got done=%0d err=%0d expected done=1 err=0", d_done, d_err);
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (ps2_clk_oe || !bus.tx_ready) saw_oe = 1'b1;
        end
        checks++;
        if (saw_oe !== 1'b0) begin
            errors++;
            $display("FAIL busy_requests_dropped: got extra frame %b expected 0", saw_oe);
        end
    endtask

    task automatic test_random_frames();
        for (int i = 0; i < 3; i++) begin
            run_frame("random", 8'($urandom), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL done_error_together: got %0d expected 0", both_cnt);
        end
        checks++;
        if (ready_late != 0) begin
            errors++;
            $display("FAIL ready_after_pulse: got %0d late cycles expected 0", ready_late);
        end
        checks++;
        if (ready_early != 0) begin
            errors++;
            $display("FAIL ready_during_pulse: got %0d cycles expected 0", ready_early);
        end
    endtask

    initial begin
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        test_reset();
        test_inhibit_and_ack();
        test_nack();
        test_timeout();
        test_reset_mid_frame();
        test_glitch_and_busy();
        test_random_frames();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "time limit");
    end

endmodule
